pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
//  - Tracks in-flight destination registers for every stage after decode.
//  - Produces per-operand forward selects and load-use stalls/bubbles.
//  - Handles branch-redirect flushes and back-end holds on data-memory busy.
//  - Replaces the single global stall with split front-end/back-end control; sits beside decode_stage.
// PARAMETERS
//  DEPTH        3  tracked stages after decode (0=EX, 1=MEM, ... DEPTH-1=WB)
//  REG_AW       5  register address width
//  LOAD_RDY     2  first stage index whose load result is forwardable to an EX consumer
//  CNT_W        16 width of the saturating performance counters
// PORTS
//  clk          in  1        clock
//  rst          in  1        synchronous reset, active-high
//  dec_valid    in  1        decode slot holds a real instruction
//  dec_rs1      in  REG_AW   decode source 1
//  dec_rs2      in  REG_AW   decode source 2
//  dec_rs1_used in  1        instruction reads rs1
//  dec_rs2_used in  1        instruction reads rs2
//  dec_rd       in  REG_AW   decode destination
//  dec_wr_en    in  1        instruction writes rd
//  dec_is_load  in  1        instruction is a load
//  redirect     in  1        decode resolved a taken branch/jump (npc_control)
//  mem_busy     in  1        data memory not ready; back end must hold
//  stall_fe     out 1        hold PC, IF/Dec register
//  bubble_ex    out 1        load Dec/Exec register with a NOP
//  stall_be     out 1        hold Exec/Mem/WB registers
//  flush_dec    out 1        zero Instruction_Dec next edge (wrong-path fetch)
//  fwd_sel_a    out clog2(DEPTH)  rs1 select, registered by top into Exec
//  fwd_sel_b    out clog2(DEPTH)  rs2 select
//  stage_valid  out DEPTH    valid bit per tracked stage
//  stall_cnt    out CNT_W    saturating count of cycles with stall_fe=1
//  flush_cnt    out CNT_W    saturating count of flush_dec pulses
// BEHAVIOUR
//  - Table entry[i] = {valid, rd, wr_en, is_load}, i = 0..DEPTH-1.
//  - Reset: all entries invalid; all outputs 0; counters 0. Reset mid-operation discards all entries.
//  - Match on entry i for source s: valid & wr_en & rd==s & s!=0 & s_used.
//    Youngest (lowest i) match wins; entry DEPTH-1 is never forwarded (register file write-through).
//  - fwd_sel = i+1 for a match at i <= DEPTH-2; otherwise 0 (register file).
//  - Load-use hazard: a winning match with is_load & (i+1) < LOAD_RDY.
//  - hazard = dec_valid & (load-use on rs1 | load-use on rs2); combinational, same cycle.
//  - mem_busy=1: stall_fe=1, stall_be=1, bubble_ex=0, flush_dec=0; table holds. mem_busy dominates all.
//  - Else hazard=1: stall_fe=1, bubble_ex=1, stall_be=0, flush_dec=0; redirect ignored
//    (branch re-resolves next cycle). Table shifts with entry[0] <= invalid.
//  - Else: stall_fe=0, flush_dec=redirect & dec_valid. Table shifts with entry[0] <= decode fields
//    (valid = dec_valid); entry[i] <= entry[i-1].
//  - fwd_sel_* is forced to 0 when hazard or !dec_valid.
//  - Counters: +1 on the respective event, saturate at all-ones, never wrap.
//  - Latency: all outputs are combinational from inputs and the table; the table updates on the clk edge.
// STRUCTURE
//  - Shared package hazard_pkg: entry struct typedef, FSEL_W = $clog2(DEPTH), FSEL_RF = 0.
//  - One sub-module, hazard_src_match: per-source youngest-match priority encoder, instantiated twice.
//  - Remainder is the shift table, stall/flush priority logic and counters.
// TESTING
//  - ADD x5 in EX, dependent ADD reads x5 in Dec -> fwd_sel_a=1, no stall.
//  - LW x6 in EX, Dec reads x6 with LOAD_RDY=2 -> stall_fe=1, bubble_ex=1 for 1 cycle;
//    next cycle fwd_sel=2, stall_cnt=1.
//  - x5 written in EX and MEM, Dec reads x5 -> fwd_sel_a=1 (youngest); dec_rs1=0 with x0 in flight -> 0.
//  - Load-use hazard with mem_busy=1 for 3 cycles -> stall_be=1, bubble_ex=0, table frozen;
//    hazard resolves after release.
//  - redirect=1 with no hazard -> flush_dec=1, flush_cnt=1; redirect during hazard -> flush_dec=0.
//  - Force stall_cnt to 2^CNT_W-1, stall again -> value holds; assert rst mid-stream
//    -> stage_valid=0 and counters 0 next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults, table entry type and forward-select encoding for the hazard controller
package hazard_pkg;
  localparam int DEF_DEPTH = 3;
  localparam int DEF_LOAD_RDY = 2;
  localparam int DEF_CNT_W = 16;
  localparam int REG_AW = 5;
  localparam int FSEL_W = $clog2(DEF_DEPTH);
  localparam int FSEL_RF = 0;
  typedef struct packed {
    logic valid;
    logic [REG_AW-1:0] rd;
    logic wr_en;
    logic is_load;
  } entry_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: decode/stall/forward bundle; master = pipeline side, slave = hazard controller
interface pipeline_hazard_ctrl_if #(parameter int DEPTH = 3, parameter int CNT_W = 16);
  import hazard_pkg::*;
  logic dec_valid;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic dec_rs1_used;
  logic dec_rs2_used;
  logic [REG_AW-1:0] dec_rd;
  logic dec_wr_en;
  logic dec_is_load;
  logic redirect;
  logic mem_busy;
  logic stall_fe;
  logic bubble_ex;
  logic stall_be;
  logic flush_dec;
  logic [$clog2(DEPTH)-1:0] fwd_sel_a;
  logic [$clog2(DEPTH)-1:0] fwd_sel_b;
  logic [DEPTH-1:0] stage_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master(
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_wr_en, dec_is_load,
           redirect, mem_busy,
    input  stall_fe, bubble_ex, stall_be, flush_dec, fwd_sel_a, fwd_sel_b, stage_valid, stall_cnt, flush_cnt
  );
  modport slave(
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_wr_en, dec_is_load,
           redirect, mem_busy,
    output stall_fe, bubble_ex, stall_be, flush_dec, fwd_sel_a, fwd_sel_b, stage_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_src_match.sv
// hazard_src_match: youngest in-flight writer of one source -> forward select (0 = regfile) and load-use flag
module hazard_src_match import hazard_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LOAD_RDY = DEF_LOAD_RDY
) (
  input  entry_t [DEPTH-1:0] tbl,
  input  logic [REG_AW-1:0] src,
  input  logic used,
  output logic [$clog2(DEPTH)-1:0] sel,
  output logic load_use
);
  localparam int FW = $clog2(DEPTH);
  always_comb begin
    sel = FW'(FSEL_RF);
    load_use = 1'b0;
    for (int i = DEPTH - 2; i >= 0; i--)
      if (tbl[i].valid && tbl[i].wr_en && tbl[i].rd == src && src != '0 && used) begin
        sel = FW'(i + 1);
        load_use = tbl[i].is_load && (i + 1 < LOAD_RDY);
      end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: in-flight rd table, forward selects, load-use stall/bubble, busy hold, redirect flush, counters
module pipeline_hazard_ctrl import hazard_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LOAD_RDY = DEF_LOAD_RDY,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int FW = $clog2(DEPTH);
  entry_t [DEPTH-1:0] tbl;
  entry_t dec_e;
  logic [FW-1:0] sel_a, sel_b;
  logic lu_a, lu_b, hazard;
  hazard_src_match #(.DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)) u_a (
    .tbl(tbl), .src(bus.dec_rs1), .used(bus.dec_rs1_used), .sel(sel_a), .load_use(lu_a)
  );
  hazard_src_match #(.DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)) u_b (
    .tbl(tbl), .src(bus.dec_rs2), .used(bus.dec_rs2_used), .sel(sel_b), .load_use(lu_b)
  );
  assign hazard = bus.dec_valid & (lu_a | lu_b);
  assign dec_e = {bus.dec_valid, bus.dec_rd, bus.dec_wr_en, bus.dec_is_load};
  always_comb begin
    bus.stall_fe = bus.mem_busy | hazard;
    bus.stall_be = bus.mem_busy;
    bus.bubble_ex = !bus.mem_busy & hazard;
    bus.flush_dec = !bus.mem_busy & !hazard & bus.redirect & bus.dec_valid;
    bus.fwd_sel_a = (hazard | !bus.dec_valid) ? FW'(FSEL_RF) : sel_a;
    bus.fwd_sel_b = (hazard | !bus.dec_valid) ? FW'(FSEL_RF) : sel_b;
    for (int i = 0; i < DEPTH; i++) bus.stage_valid[i] = tbl[i].valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl <= '0;
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (!bus.mem_busy) tbl <= {tbl[DEPTH-2:0], hazard ? entry_t'('0) : dec_e};
      if (bus.stall_fe && !(&bus.stall_cnt)) bus.stall_cnt <= bus.stall_cnt + 1'b1;
      if (bus.flush_dec && !(&bus.flush_cnt)) bus.flush_cnt <= bus.flush_cnt + 1'b1;
    end
  end
endmodule
